// File: rtl/pc_redirect_arbiter.sv
// rtl/pc_redirect_arbiter.sv - oldest-first redirect arbiter with per-source slots and younger squash
module pc_redirect_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 6,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PC_WIDTH-1:0]  req_pc,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  req_issue_id,
    output logic [NUM_REQ-1:0]           slot_full,
    output logic                         redir_valid,
    output logic [PC_WIDTH-1:0]          redir_pc,
    output logic [ID_WIDTH-1:0]          redir_issue_id,
    input  logic                         redir_ready,
    output logic [15:0]                  drop_cnt
);

    // Up to two discards per source per cycle (slot squash + pulse squash, or one collision).
    localparam int INC_W = $clog2(2 * NUM_REQ + 1);

    // a is older than b when the modular difference lands in the upper half of the ID space.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    logic [NUM_REQ-1:0]  slot_v;
    logic [PC_WIDTH-1:0] slot_pc [NUM_REQ];
    logic [ID_WIDTH-1:0] slot_id [NUM_REQ];

    logic [NUM_REQ-1:0]  slot_v_nx;
    logic [PC_WIDTH-1:0] slot_pc_nx [NUM_REQ];
    logic [ID_WIDTH-1:0] slot_id_nx [NUM_REQ];

    logic [PC_WIDTH-1:0] in_pc [NUM_REQ];
    logic [ID_WIDTH-1:0] in_id [NUM_REQ];

    logic                accept;
    logic                load;
    logic [NUM_REQ-1:0]  pulse_ok;
    logic [NUM_REQ-1:0]  slot_sq;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  keep;
    logic [NUM_REQ-1:0]  sel_oh;
    logic                sel_found;
    logic [PC_WIDTH-1:0] sel_pc;
    logic [ID_WIDTH-1:0] sel_id;
    logic [INC_W-1:0]    drop_inc;
    logic [16:0]         drop_sum;
    logic [15:0]         drop_nx;

    assign slot_full = slot_v;

    // Squash filtering, oldest-eligible selection and slot next-state with drop accounting.
    always_comb begin
        accept    = redir_valid && redir_ready;
        load      = !redir_valid || accept;
        pulse_ok  = '0;
        slot_sq   = '0;
        elig      = '0;
        keep      = '0;
        sel_oh    = '0;
        sel_found = 1'b0;
        sel_pc    = '0;
        sel_id    = '0;
        drop_inc  = '0;
        slot_v_nx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_pc[i]      = req_pc[i*PC_WIDTH +: PC_WIDTH];
            in_id[i]      = req_issue_id[i*ID_WIDTH +: ID_WIDTH];
            slot_pc_nx[i] = slot_pc[i];
            slot_id_nx[i] = slot_id[i];
        end

        // The accepted redirect kills anything younger, both held and arriving.
        for (int i = 0; i < NUM_REQ; i++) begin
            pulse_ok[i] = req_valid[i] && !(accept && is_older(redir_issue_id, in_id[i]));
            slot_sq[i]  = slot_v[i] && accept && is_older(redir_issue_id, slot_id[i]);
            elig[i]     = slot_v[i] && !slot_sq[i];
        end

        // Strictly-older comparison keeps the lowest index on an ID tie.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i] && (!sel_found || is_older(slot_id[i], sel_id))) begin
                sel_found = 1'b1;
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_pc    = slot_pc[i];
                sel_id    = slot_id[i];
            end
        end

        // Order per source: pulse filter, selection clear, then capture.
        for (int i = 0; i < NUM_REQ; i++) begin
            keep[i]      = elig[i] && !(load && sel_oh[i]);
            slot_v_nx[i] = keep[i];
            if (slot_sq[i]) begin
                drop_inc = drop_inc + INC_W'(1);
            end
            if (req_valid[i] && !pulse_ok[i]) begin
                drop_inc = drop_inc + INC_W'(1);
            end
            if (pulse_ok[i]) begin
                if (!keep[i]) begin
                    slot_v_nx[i]  = 1'b1;
                    slot_pc_nx[i] = in_pc[i];
                    slot_id_nx[i] = in_id[i];
                end else begin
                    drop_inc = drop_inc + INC_W'(1);
                    if (is_older(in_id[i], slot_id[i])) begin
                        slot_pc_nx[i] = in_pc[i];
                        slot_id_nx[i] = in_id[i];
                    end
                end
            end
        end

        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
        drop_nx  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Slot, output and drop-counter registers; reset discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v         <= '0;
            redir_valid    <= 1'b0;
            redir_pc       <= '0;
            redir_issue_id <= '0;
            drop_cnt       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_pc[i] <= '0;
                slot_id[i] <= '0;
            end
        end else begin
            slot_v   <= slot_v_nx;
            drop_cnt <= drop_nx;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_pc[i] <= slot_pc_nx[i];
                slot_id[i] <= slot_id_nx[i];
            end
            if (load) begin
                redir_valid <= sel_found;
                if (sel_found) begin
                    redir_pc       <= sel_pc;
                    redir_issue_id <= sel_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// tb/tb_pc_redirect_arbiter.sv - scoreboard bench for pc_redirect_arbiter
module tb_pc_redirect_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 6;
    localparam int PC_WIDTH = 32;
    localparam int E_W      = PC_WIDTH + ID_WIDTH;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*PC_WIDTH-1:0] req_pc;
    logic [NUM_REQ*ID_WIDTH-1:0] req_issue_id;
    logic [NUM_REQ-1:0]          slot_full;
    logic                        redir_valid;
    logic [PC_WIDTH-1:0]         redir_pc;
    logic [ID_WIDTH-1:0]         redir_issue_id;
    logic                        redir_ready;
    logic [15:0]                 drop_cnt;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [15:0]  exp_drop = '0;
    logic [E_W-1:0] sb [$];

    pc_redirect_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
        .req_issue_id(req_issue_id), .slot_full(slot_full), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_issue_id(redir_issue_id), .redir_ready(redir_ready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic [ID_WIDTH-1:0] id, input logic [PC_WIDTH-1:0] pc);
        req_valid[src] = 1'b1;
        req_issue_id[src*ID_WIDTH +: ID_WIDTH] = id;
        req_pc[src*PC_WIDTH +: PC_WIDTH] = pc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if ({redir_valid, redir_pc, redir_issue_id, slot_full, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b pc=%h id=%0d full=%b drop=%0d, required all zero",
                     redir_valid, redir_pc, redir_issue_id, slot_full, drop_cnt);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        logic [E_W-1:0] exp;
        redir_ready = 1'b1;
        set_req(0, 6'd5, 32'h1000);
        sb.push_back({32'h1000, 6'd5});
        tick;
        req_valid = '0;
        n_cmp++;
        if (slot_full !== 4'b0001 || redir_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_t1: got full=%b v=%0b, required full=0001 v=0", slot_full, redir_valid);
        end
        tick;
        n_cmp++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (redir_valid !== 1'b1 || {redir_pc, redir_issue_id} !== exp) begin
            n_err++;
            $display("FAIL single_t2: got v=%0b pc=%h id=%0d, required v=1 pc=%h id=%0d",
                     redir_valid, redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
        end
        tick;
        n_cmp++;
        if (redir_valid !== 1'b0 || drop_cnt !== exp_drop) begin
            n_err++;
            $display("FAIL single_t3: got v=%0b drop=%0d, required v=0 drop=%0d", redir_valid, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_same_cycle;
        logic [E_W-1:0] exp;
        redir_ready = 1'b1;
        set_req(1, 6'd9, 32'hA000);
        set_req(2, 6'd7, 32'hB000);
        sb.push_back({32'hB000, 6'd7});
        exp_drop = exp_drop + 16'd1;
        tick;
        req_valid = '0;
        n_cmp++;
        if (slot_full !== 4'b0110) begin
            n_err++;
            $display("FAIL same_slots: got full=%b, required 0110", slot_full);
        end
        for (int c = 0; c < 4; c++) begin
            if (redir_valid && redir_ready) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if ({redir_pc, redir_issue_id} !== exp) begin
                    n_err++;
                    $display("FAIL same_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                             redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                end
            end
            tick;
        end
        n_cmp++;
        if (redir_valid !== 1'b0 || drop_cnt !== exp_drop || slot_full !== 4'b0000) begin
            n_err++;
            $display("FAIL same_end: got v=%0b drop=%0d full=%b, required v=0 drop=%0d full=0000",
                     redir_valid, drop_cnt, slot_full, exp_drop);
        end
    endtask

    task automatic test_wrap;
        logic [E_W-1:0] exp;
        redir_ready = 1'b1;
        set_req(0, 6'd62, 32'hC000);
        set_req(3, 6'd1, 32'hD000);
        sb.push_back({32'hC000, 6'd62});
        exp_drop = exp_drop + 16'd1;
        tick;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            if (redir_valid && redir_ready) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if ({redir_pc, redir_issue_id} !== exp) begin
                    n_err++;
                    $display("FAIL wrap_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                             redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                end
            end
            tick;
        end
        n_cmp++;
        if (redir_valid !== 1'b0 || drop_cnt !== exp_drop) begin
            n_err++;
            $display("FAIL wrap_end: got v=%0b drop=%0d, required v=0 drop=%0d", redir_valid, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_backpressure;
        logic [E_W-1:0] exp;
        redir_ready = 1'b0;
        set_req(0, 6'd20, 32'h2020);
        sb.push_back({32'h2020, 6'd20});
        tick;
        req_valid = '0;
        tick;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                set_req(1, 6'd18, 32'h1818);
                sb.push_back({32'h1818, 6'd18});
            end
            n_cmp++;
            if (redir_valid !== 1'b1 || redir_issue_id !== 6'd20 || redir_pc !== 32'h2020) begin
                n_err++;
                $display("FAIL bp_stable: cycle %0d got v=%0b pc=%h id=%0d, required v=1 pc=2020 id=20",
                         c, redir_valid, redir_pc, redir_issue_id);
            end
            tick;
            req_valid = '0;
        end
        redir_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (redir_valid && redir_ready) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if ({redir_pc, redir_issue_id} !== exp) begin
                    n_err++;
                    $display("FAIL bp_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                             redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                end
            end
            tick;
        end
        n_cmp++;
        if (drop_cnt !== exp_drop || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_end: got drop=%0d left=%0d, required drop=%0d left=0", drop_cnt, sb.size(), exp_drop);
        end
    endtask

    task automatic test_collision;
        logic [E_W-1:0] exp;
        for (int r = 0; r < 2; r++) begin
            redir_ready = 1'b0;
            set_req(1, (r == 0) ? 6'd30 : 6'd40, 32'hE000 + 32'(r));
            sb.push_back({32'hE000 + 32'(r), (r == 0) ? 6'd30 : 6'd40});
            tick;
            req_valid = '0;
            tick;
            set_req(0, (r == 0) ? 6'd10 : 6'd35, 32'hF000);
            tick;
            req_valid = '0;
            n_cmp++;
            if (slot_full !== 4'b0001) begin
                n_err++;
                $display("FAIL coll_slot: round %0d got full=%b, required 0001", r, slot_full);
            end
            set_req(0, (r == 0) ? 6'd12 : 6'd33, 32'hF100);
            exp_drop = exp_drop + 16'd1;
            sb.push_back((r == 0) ? {32'hF000, 6'd10} : {32'hF100, 6'd33});
            tick;
            req_valid = '0;
            n_cmp++;
            if (drop_cnt !== exp_drop || redir_issue_id !== ((r == 0) ? 6'd30 : 6'd40)) begin
                n_err++;
                $display("FAIL coll_drop: round %0d got drop=%0d id=%0d, required drop=%0d", r, drop_cnt,
                         redir_issue_id, exp_drop);
            end
            redir_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (redir_valid && redir_ready) begin
                    n_cmp++;
                    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                    if ({redir_pc, redir_issue_id} !== exp) begin
                        n_err++;
                        $display("FAIL coll_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                                 redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                    end
                end
                tick;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [E_W-1:0] exp;
        logic [7:0] vmask;
        vmask = '0;
        redir_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                set_req(c, 6'(20 - c), 32'h3000 + 32'(4 * c));
                sb.push_back({32'h3000 + 32'(4 * c), 6'(20 - c)});
            end
            vmask[c] = redir_valid;
            if (redir_valid && redir_ready) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if ({redir_pc, redir_issue_id} !== exp) begin
                    n_err++;
                    $display("FAIL b2b_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                             redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                end
            end
            tick;
            req_valid = '0;
        end
        n_cmp++;
        if (vmask !== 8'b0011_1100 || drop_cnt !== exp_drop) begin
            n_err++;
            $display("FAIL b2b_rate: got valid mask=%b drop=%0d, required 00111100 drop=%0d", vmask, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset_mid;
        logic [E_W-1:0] exp;
        redir_ready = 1'b0;
        set_req(0, 6'd50, 32'h5000);
        tick;
        req_valid = '0;
        tick;
        set_req(1, 6'd51, 32'h5100);
        set_req(2, 6'd52, 32'h5200);
        tick;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({redir_valid, redir_pc, redir_issue_id, slot_full, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%0b pc=%h id=%0d full=%b drop=%0d, required all zero",
                     redir_valid, redir_pc, redir_issue_id, slot_full, drop_cnt);
        end
        sb.delete();
        exp_drop = '0;
        @(negedge clk);
        rst_n = 1'b1;
        redir_ready = 1'b1;
        tick;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (redir_valid !== 1'b0 || slot_full !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_idle: cycle %0d got v=%0b full=%b, required v=0 full=0000", c, redir_valid, slot_full);
            end
            tick;
        end
        set_req(3, 6'd7, 32'h7777);
        sb.push_back({32'h7777, 6'd7});
        tick;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            if (redir_valid && redir_ready) begin
                n_cmp++;
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                if ({redir_pc, redir_issue_id} !== exp) begin
                    n_err++;
                    $display("FAIL reset_sb: got pc=%h id=%0d, required pc=%h id=%0d",
                             redir_pc, redir_issue_id, exp[E_W-1:ID_WIDTH], exp[ID_WIDTH-1:0]);
                end
            end
            tick;
        end
        n_cmp++;
        if (sb.size() != 0 || drop_cnt !== exp_drop) begin
            n_err++;
            $display("FAIL final_sb: got left=%0d drop=%0d, required left=0 drop=%0d", sb.size(), drop_cnt, exp_drop);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_pc       = '0;
        req_issue_id = '0;
        redir_ready  = 1'b0;
        test_reset();
        test_single();
        test_same_cycle();
        test_wrap();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_arbiter.md
# pc_redirect_arbiter

Collects single-cycle `pc_redirect_*` pulses from the control-flow sub-SICs (JR, branch, exception units) and serialises them into one valid/ready redirect stream toward fetch. Sources cannot be back-pressured, so every pulse is captured in a per-source slot. Among pending redirects, the oldest by issue ID is forwarded first. An accepted redirect squashes every pending or arriving redirect younger than itself.

## Interface
- `NUM_REQ`, default 4: number of redirect sources, range 1..8.
- `ID_WIDTH`, default 6: issue-ID width. The in-flight window is strictly less than 2^(ID_WIDTH-1).
- `PC_WIDTH`, default 32: redirect target width.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, NUM_REQ: one-cycle redirect pulse per source.
- `req_pc`, input, NUM_REQ×PC_WIDTH: target PC per source.
- `req_issue_id`, input, NUM_REQ×ID_WIDTH: issue ID of the redirecting instruction.
- `slot_full`, output, NUM_REQ: per-source slot occupied (debug/perf only).
- `redir_valid`, output, 1: redirect offered to fetch.
- `redir_pc`, output, PC_WIDTH: redirect target.
- `redir_issue_id`, output, ID_WIDTH: issue ID of the offered redirect.
- `redir_ready`, input, 1: fetch accepts the redirect this cycle.
- `drop_cnt`, output, 16: saturating count of redirects discarded as younger.

## Operation
- **Age rule.** A is older than B iff bit [ID_WIDTH-1] of (A − B mod 2^ID_WIDTH) is 1. Wrap-around is handled by the modular subtract. Equal IDs across sources are not legal inputs. If they occur anyway, the lowest source index wins.
- **Per-source slot** holds {valid, pc, id}.
  - Pulse into an empty slot: captured.
  - Pulse into a full slot: the older of the two is kept. The other is dropped and `drop_cnt` increments.
- **Output register** holds {valid, pc, id}. It loads when empty or when it is accepted this cycle (`redir_valid && redir_ready`).
  - The load source is the oldest eligible slot.
  - The chosen slot is cleared on the same edge, unless a same-cycle pulse for that source refills it.
- **Squash on accept with ID X.** On that edge:
  - every slot with ID younger than X is cleared;
  - every same-cycle `req_valid` pulse younger than X is discarded;
  - such slots and pulses are also ineligible for the reload in that cycle.
  - Each squashed slot or pulse adds 1 to `drop_cnt`. The multi-increment is summed in one cycle and saturates at 16'hFFFF.
- **Stability.** While `redir_valid && !redir_ready`, `redir_pc` and `redir_issue_id` hold stable. A newly arrived older redirect waits in its slot; it is not allowed to replace the output.
- **Older-than-output redirects.** A pending slot older than the current output is forwarded after the output is accepted.
- **Empty selection.** If no slot is eligible, `redir_valid` deasserts after acceptance.

## Timing
- **Reset.** All slots invalid, `redir_valid`=0, `redir_pc`=0, `redir_issue_id`=0, `slot_full`=0, `drop_cnt`=0. Reset mid-operation discards all pending redirects immediately (asynchronous).
- **Latency.**
  - Pulse in cycle T into an empty slot sets `slot_full` in T+1.
  - With the output register empty, `redir_valid`=1 in T+2.
- **Throughput.** One redirect per cycle with `redir_ready` held high. Back-to-back accepts reload the output every cycle from pending slots.
- **Simultaneous events.** Capture, selection-clear and squash for one source in the same cycle are resolved in this order: squash filter on the input pulse, then slot clear due to selection, then capture.
- **Outputs.** `slot_full` is the registered slot valid. All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single redirect.** Reset, then src0 pulses id=5, pc=0x1000 at T, `redir_ready`=1 → `redir_valid`=1 at T+2 with pc=0x1000, id=5. Deasserts at T+3. `drop_cnt`=0.
- **Same-cycle ordering.** Src1 id=9 and src2 id=7 pulse the same cycle, ready=1 → id=7 offered first. Its accept squashes id=9. Only one redirect is seen; `drop_cnt`=1.
- **Wrap-around.** ID_WIDTH=6: src0 id=62 and src3 id=1 pulse together → id=62 judged older and offered. Accept squashes id=1; `drop_cnt`=1.
- **Backpressure with an older arrival.** Output holds id=20 with ready=0 for 5 cycles. Src1 pulses id=18 during the stall → output stays id=20, stable. After accept, id=18 is offered next cycle and is not squashed.
- **Full-slot collision.** Src0 slot holds id=10. Src0 pulses id=12 while the output is stalled → slot keeps id=10; `drop_cnt`=1. Repeat with pulse id=8 → slot becomes id=8; `drop_cnt`=2.
- **Reset mid-flight.** Slots and output full, `rst_n` asserted low mid-cycle → all outputs 0 immediately. No redirect emerges after release until a new pulse arrives.
